// File: rtl/mfetch_const_pkg.sv
// Shared types and constants for the MCONST instruction fetch stage.
package mfetch_const_pkg;

    localparam int WORD_W      = 32;
    localparam int INSTR_WORDS = 2;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_FETCH_OP    = 2'd1,
        ST_FETCH_CONST = 2'd2,
        ST_WAIT_OUT    = 2'd3
    } state_t;

    function automatic logic is_fetch(input state_t st);
        return (st == ST_FETCH_OP) || (st == ST_FETCH_CONST);
    endfunction

endpackage

// File: rtl/mfetch_outreg.sv
// Output register holding {pc, op, const} for decode/execute.
// Load lands on the next edge; contents hold while valid and not ready; flush clears valid.
module mfetch_outreg
    import mfetch_const_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic                  i_flush,
    input  logic                  i_ready,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic [WORD_W-1:0]     i_op,
    input  logic [WORD_W-1:0]     i_const,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [WORD_W-1:0]     o_op,
    output logic [WORD_W-1:0]     o_const
);

    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [WORD_W-1:0]     r_op;
    logic [WORD_W-1:0]     r_const;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_op    <= '0;
            r_const <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            // The fetch FSM only loads when the register is empty or draining.
            if (i_load && !i_flush) begin
                r_pc    <= i_pc;
                r_op    <= i_op;
                r_const <= i_const;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_op    = r_op;
    assign o_const = r_const;

endmodule

// File: rtl/mfetch_const.sv
// Two-word instruction fetch (opcode + 32-bit constant) feeding MCONST, with jump/flush.
// 2 cycles plus memory wait states to out_valid; stalls in WAIT_OUT with mem_req low under backpressure.
module mfetch_const
    import mfetch_const_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_run,
    output logic                  o_mem_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_ack,
    input  logic [WORD_W-1:0]     i_mem_rdata,
    input  logic                  i_jump_valid,
    input  logic [ADDR_WIDTH-1:0] i_jump_addr,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [ADDR_WIDTH-1:0] o_out_pc,
    output logic [WORD_W-1:0]     o_out_op,
    output logic [WORD_W-1:0]     o_out_const,
    output logic                  o_busy
);

    localparam logic [ADDR_WIDTH-1:0] C_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] C_STEP = ADDR_WIDTH'(INSTR_WORDS);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_flush;
    logic [WORD_W-1:0]     r_op;
    logic [WORD_W-1:0]     r_const;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  w_flush_nxt;
    logic [WORD_W-1:0]     w_op_nxt;
    logic [WORD_W-1:0]     w_const_nxt;
    logic [WORD_W-1:0]     w_ld_const;
    logic                  w_req;
    logic                  w_ack;
    logic                  w_drain;
    logic                  w_load;
    logic                  w_out_flush;
    logic                  w_out_valid;
    logic [ADDR_WIDTH-1:0] w_jpc;
    logic [ADDR_WIDTH-1:0] w_pc_step;
    state_t                w_resume;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_flush <= 1'b0;
            r_op    <= '0;
            r_const <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_addr  <= w_addr_nxt;
            r_flush <= w_flush_nxt;
            r_op    <= w_op_nxt;
            r_const <= w_const_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_addr_nxt  = r_addr;
        w_flush_nxt = r_flush;
        w_op_nxt    = r_op;
        w_const_nxt = r_const;
        w_ld_const  = r_const;
        w_load      = 1'b0;
        w_out_flush = 1'b0;
        w_req       = is_fetch(r_state);
        w_ack       = w_req && i_mem_ack;
        w_drain     = w_out_valid && i_out_ready;
        w_jpc       = i_jump_addr & ~C_ONE;
        w_pc_step   = r_pc + C_STEP;
        w_resume    = i_run ? ST_FETCH_OP : ST_IDLE;

        if (i_jump_valid) begin
            w_pc_nxt    = w_jpc;
            w_out_flush = 1'b1;
            // An unacked request cannot be withdrawn: hold it and drop its data later.
            if (w_req && !i_mem_ack) begin
                w_flush_nxt = 1'b1;
            end else begin
                w_flush_nxt = 1'b0;
                w_state_nxt = w_resume;
                w_addr_nxt  = w_jpc;
            end
        end else if (r_flush) begin
            if (w_ack) begin
                w_flush_nxt = 1'b0;
                w_state_nxt = w_resume;
                w_addr_nxt  = r_pc;
            end
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_run) begin
                        w_state_nxt = ST_FETCH_OP;
                        w_addr_nxt  = r_pc;
                    end
                end
                ST_FETCH_OP: begin
                    if (w_ack) begin
                        w_op_nxt    = i_mem_rdata;
                        w_state_nxt = ST_FETCH_CONST;
                        w_addr_nxt  = r_pc + C_ONE;
                    end
                end
                ST_FETCH_CONST: begin
                    if (w_ack) begin
                        w_const_nxt = i_mem_rdata;
                        w_ld_const  = i_mem_rdata;
                        if (!w_out_valid || w_drain) begin
                            w_load      = 1'b1;
                            w_pc_nxt    = w_pc_step;
                            w_addr_nxt  = w_pc_step;
                            w_state_nxt = w_resume;
                        end else begin
                            w_state_nxt = ST_WAIT_OUT;
                        end
                    end
                end
                ST_WAIT_OUT: begin
                    if (w_drain) begin
                        w_load      = 1'b1;
                        w_pc_nxt    = w_pc_step;
                        w_addr_nxt  = w_pc_step;
                        w_state_nxt = w_resume;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    mfetch_outreg #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_outreg (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_flush (w_out_flush),
        .i_ready (i_out_ready),
        .i_pc    (r_pc),
        .i_op    (r_op),
        .i_const (w_ld_const),
        .o_valid (w_out_valid),
        .o_pc    (o_out_pc),
        .o_op    (o_out_op),
        .o_const (o_out_const)
    );

    assign o_mem_req   = w_req;
    assign o_mem_addr  = r_addr;
    assign o_out_valid = w_out_valid;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mfetch_const.sv
// Bench for mfetch_const: wait-state memory model, scoreboard of expected instructions.
module tb_mfetch_const;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        jump_valid;
    logic [15:0] jump_addr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [31:0] out_op;
    logic [31:0] out_const;
    logic        busy;

    logic        run4;
    logic        mem_req4;
    logic [3:0]  mem_addr4;
    logic        mem_ack4;
    logic [31:0] mem_rdata4;
    logic        out_valid4;
    logic [3:0]  out_pc4;
    logic [31:0] out_op4;
    logic [31:0] out_const4;
    logic        busy4;
    logic        jump4 = 1'b0;
    logic [3:0]  jaddr4 = 4'd0;
    logic        ready4 = 1'b1;

    always #5 clk = ~clk;

    mfetch_const #(.ADDR_WIDTH(16), .RESET_PC(16'd0)) dut (
        .i_clk(clk), .i_reset(reset), .i_run(run),
        .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .i_jump_valid(jump_valid), .i_jump_addr(jump_addr),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_pc(out_pc),
        .o_out_op(out_op), .o_out_const(out_const), .o_busy(busy)
    );

    mfetch_const #(.ADDR_WIDTH(4), .RESET_PC(4'd14)) dut4 (
        .i_clk(clk), .i_reset(reset), .i_run(run4),
        .o_mem_req(mem_req4), .o_mem_addr(mem_addr4), .i_mem_ack(mem_ack4), .i_mem_rdata(mem_rdata4),
        .i_jump_valid(jump4), .i_jump_addr(jaddr4),
        .o_out_valid(out_valid4), .i_out_ready(ready4), .o_out_pc(out_pc4),
        .o_out_op(out_op4), .o_out_const(out_const4), .o_busy(busy4)
    );

    // Program memory with a programmable number of wait states per word.
    logic [31:0] mem [0:255];
    int unsigned wait_n = 0;
    int unsigned wcnt = 0;
    assign mem_ack   = mem_req && (wcnt >= wait_n);
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end

    assign mem_ack4   = mem_req4;
    assign mem_rdata4 = 32'hA5A50000 | {28'd0, mem_addr4};

    int n_total = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] op;
        logic [31:0] cst;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    task automatic push_exp(input logic [15:0] pc);
        logic [7:0] a;
        logic [7:0] b;
        exp_t e;
        a = pc[7:0];
        b = a + 8'd1;
        e.pc  = pc;
        e.op  = mem[a];
        e.cst = mem[b];
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("sb_pc", 32'(out_pc), 32'(mon_e.pc));
                check("sb_op", out_op, mon_e.op);
                check("sb_const", out_const, mon_e.cst);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        run = 1'b0;
        jump_valid = 1'b0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        int acks;
        int n0;
        int n1;
        for (int i = 0; i < 256; i++) mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
        mem[0] = 32'h00000005;
        mem[1] = 32'h1C8F2F12;
        reset = 1'b0;
        run = 1'b0;
        run4 = 1'b0;
        jump_valid = 1'b0;
        jump_addr = 16'd0;
        out_ready = 1'b1;
        #2;
        reset = 1'b1;
        #2;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc", 32'(out_pc), 32'd0);
        check("rst_op", out_op, 32'd0);
        check("rst_const", out_const, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr4", 32'(mem_addr4), 32'd14);
        do_reset();

        // Zero-wait stream of two instructions.
        wait_n = 0;
        push_exp(16'd0);
        push_exp(16'd2);
        run = 1'b1;
        step();
        check("t1_e1_valid", 32'(out_valid), 32'd0);
        check("t1_e1_addr", 32'(mem_addr), 32'd0);
        step();
        check("t1_e2_valid", 32'(out_valid), 32'd0);
        check("t1_e2_addr", 32'(mem_addr), 32'd1);
        step();
        check("t1_e3_valid", 32'(out_valid), 32'd1);
        check("t1_e3_const", out_const, 32'h1C8F2F12);
        step();
        run = 1'b0;
        step();
        check("t1_e5_pc", 32'(out_pc), 32'd2);
        step(3);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_drain", 32'(sb_q.size()), 32'd0);

        // Three wait states per word.
        do_reset();
        mem[1] = 32'h3E6F9618;
        wait_n = 3;
        push_exp(16'd0);
        run = 1'b1;
        step();
        run = 1'b0;
        acks = 0; n0 = 0; n1 = 0; g = 0;
        while (!out_valid && g < 40) begin
            check("t2_busy", 32'(busy), 32'd1);
            if (mem_req) begin
                check("t2_addr", 32'(mem_addr), (acks == 0) ? 32'd0 : 32'd1);
                if (mem_addr == 16'd0) n0++;
                else n1++;
                if (mem_ack) acks++;
            end
            step();
            g++;
        end
        check("t2_timeout", 32'(out_valid), 32'd1);
        check("t2_const", out_const, 32'h3E6F9618);
        check("t2_n0", 32'(n0), 32'd4);
        check("t2_n1", 32'(n1), 32'd4);
        step(2);
        check("t2_drain", 32'(sb_q.size()), 32'd0);

        // Backpressure: second instruction parks in WAIT_OUT.
        do_reset();
        wait_n = 0;
        out_ready = 1'b0;
        push_exp(16'd0);
        push_exp(16'd2);
        run = 1'b1;
        step(4);
        run = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_pc", 32'(out_pc), 32'd0);
            check("t3_hold_const", out_const, 32'h3E6F9618);
            check("t3_hold_req", 32'(mem_req), 32'd0);
            check("t3_hold_busy", 32'(busy), 32'd1);
            step();
        end
        out_ready = 1'b1;
        step();
        check("t3_second_valid", 32'(out_valid), 32'd1);
        check("t3_second_pc", 32'(out_pc), 32'd2);
        step(3);
        check("t3_idle", 32'(busy), 32'd0);
        check("t3_drain", 32'(sb_q.size()), 32'd0);

        // Jump while FETCH_CONST waits for its ack.
        do_reset();
        wait_n = 4;
        out_ready = 1'b1;
        push_exp(16'h0040);
        run = 1'b1;
        g = 0;
        while (!(mem_req && mem_addr == 16'd1) && g < 40) begin
            step();
            g++;
        end
        check("t4_reach_fc", 32'(mem_req && mem_addr == 16'd1), 32'd1);
        jump_valid = 1'b1;
        jump_addr = 16'h0041;
        step();
        jump_valid = 1'b0;
        g = 0;
        while (!mem_ack && g < 20) begin
            check("t4_hold_req", 32'(mem_req), 32'd1);
            check("t4_hold_addr", 32'(mem_addr), 32'd1);
            check("t4_hold_valid", 32'(out_valid), 32'd0);
            step();
            g++;
        end
        check("t4_ack_seen", 32'(mem_ack), 32'd1);
        check("t4_ack_addr", 32'(mem_addr), 32'd1);
        step();
        check("t4_new_req", 32'(mem_req), 32'd1);
        check("t4_new_addr", 32'(mem_addr), 32'h40);
        check("t4_new_valid", 32'(out_valid), 32'd0);
        run = 1'b0;
        g = 0;
        while (busy && g < 60) begin
            step();
            g++;
        end
        check("t4_idle", 32'(busy), 32'd0);
        step(2);
        check("t4_drain", 32'(sb_q.size()), 32'd0);

        // Jump clears a parked output and retargets an idle fetcher.
        do_reset();
        wait_n = 0;
        out_ready = 1'b0;
        run = 1'b1;
        step();
        run = 1'b0;
        step(2);
        check("t5_valid", 32'(out_valid), 32'd1);
        jump_valid = 1'b1;
        jump_addr = 16'h0011;
        step();
        jump_valid = 1'b0;
        check("t5_cleared", 32'(out_valid), 32'd0);
        check("t5_addr", 32'(mem_addr), 32'h10);
        check("t5_busy", 32'(busy), 32'd0);
        out_ready = 1'b1;
        push_exp(16'h0010);
        run = 1'b1;
        step();
        run = 1'b0;
        step(5);
        check("t5_drain", 32'(sb_q.size()), 32'd0);

        // Address wrap with a 4-bit program counter.
        do_reset();
        run4 = 1'b1;
        step();
        check("t6_req14", 32'(mem_req4), 32'd1);
        check("t6_addr14", 32'(mem_addr4), 32'd14);
        step();
        check("t6_addr15", 32'(mem_addr4), 32'd15);
        step();
        check("t6_valid", 32'(out_valid4), 32'd1);
        check("t6_pc14", 32'(out_pc4), 32'd14);
        check("t6_op14", out_op4, 32'hA5A5000E);
        check("t6_const14", out_const4, 32'hA5A5000F);
        check("t6_addr0", 32'(mem_addr4), 32'd0);
        step();
        run4 = 1'b0;
        step();
        check("t6_pc0", 32'(out_pc4), 32'd0);
        check("t6_op0", out_op4, 32'hA5A50000);
        check("t6_const0", out_const4, 32'hA5A50001);

        // Asynchronous reset while a request is outstanding and output is valid.
        do_reset();
        wait_n = 5;
        out_ready = 1'b0;
        run = 1'b1;
        g = 0;
        while (!(out_valid && mem_req) && g < 60) begin
            step();
            g++;
        end
        check("t7_setup", 32'(out_valid && mem_req), 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t7_req", 32'(mem_req), 32'd0);
        check("t7_valid", 32'(out_valid), 32'd0);
        check("t7_addr", 32'(mem_addr), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);
        run = 1'b0;
        step();
        reset = 1'b0;
        step(2);
        check("t7_stay_idle", 32'(mem_req), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mfetch_const.md
Name: mfetch_const

Overview:
- Instruction fetch stage directly upstream of the MCONST micro-block.
- Reads two-word instructions from program memory over a req/ack handshake: word0 is the opcode/control word, word1 is the 32-bit constant operand.
- Presents {pc, op, const} to decode/execute on a valid/ready interface; out_const drives MCONST's in port unchanged.
- Supports redirect (jump) with flush of in-flight fetches.

Parameters:
- ADDR_WIDTH, 16, word-address width of program memory.
- RESET_PC, 0, word address fetched first after reset; must be even.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  fetch enable; when low, no new memory request starts.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_WIDTH  word address; stable while mem_req is high.
- mem_ack  in  1  read data valid this cycle; only meaningful while mem_req is high.
- mem_rdata  in  32  read data, sampled when mem_req and mem_ack are both high.
- jump_valid  in  1  redirect request, single-cycle pulse.
- jump_addr  in  ADDR_WIDTH  redirect target; bit 0 forced to 0.
- out_valid  out  1  instruction available.
- out_ready  in  1  consumer accepts.
- out_pc  out  ADDR_WIDTH  address of word0 of the presented instruction.
- out_op  out  32  opcode word.
- out_const  out  32  constant word; feeds MCONST.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (async): mem_req=0, mem_addr=RESET_PC, out_valid=0, out_pc=0, out_op=0, out_const=0, busy=0, pc=RESET_PC, state=IDLE, flush flag=0.
- States:
  - IDLE -> FETCH_OP when run=1.
  - FETCH_OP: mem_req=1, mem_addr=pc. On ack, stage word0 -> FETCH_CONST.
  - FETCH_CONST: mem_req=1, mem_addr=pc+1. On ack, stage word1.
    - If the output register is empty, or is being drained this cycle (out_valid & out_ready), load the output, set pc=pc+2, then go to FETCH_OP if run=1, else IDLE.
    - Otherwise go to WAIT_OUT.
  - WAIT_OUT: mem_req=0. Load the output when the register drains, set pc=pc+2, then go to FETCH_OP if run=1, else IDLE.
- Handshake rules:
  - mem_req, once raised, stays high with mem_addr stable until ack; no abort.
  - An output transfer occurs on the cycle where out_valid & out_ready are both high.
  - out_* are stable while out_valid=1 and out_ready=0.
- Throughput: a zero-wait ack (ack the same cycle req rises) gives 1 instruction per 2 cycles.
  - Latency from entering FETCH_OP to out_valid is 2 cycles plus wait states.
- pc arithmetic is modulo 2^ADDR_WIDTH.
  - Fetch at address 2^ADDR_WIDTH-2 reads word1 at all-ones; the next pc is 0.
- jump_valid:
  - pc is set to {jump_addr[ADDR_WIDTH-1:1],0}.
  - out_valid is cleared on the next edge. If out_ready was high in the jump cycle, that transfer still counts.
  - Staged words are discarded.
  - If mem_req is high and not acked in the jump cycle, set the flush flag. The pending ack completes and its data is dropped; state then becomes FETCH_OP (if run=1) or IDLE at the new pc.
  - If no request is pending, go directly to FETCH_OP (if run=1) or IDLE.
- Jump coinciding with an ack: the acked data is dropped; no flush flag is needed.
- A new jump while the flush flag is set overwrites pc; the flag stays set until the ack.
- run low: the current instruction completes through to the output; then IDLE. run has no effect on an outstanding request.
- Reset asserted mid-transaction: everything returns to reset values immediately. Memory must tolerate req dropping without ack.

Decomposition:
- Shared package: state encoding (IDLE, FETCH_OP, FETCH_CONST, WAIT_OUT) and INSTR_WORDS=2.
  - The same package also holds the 32-bit word width constant.
- One natural sub-module: mfetch_outreg. It holds the output register (out_pc/op/const, out_valid), with load, drain and flush inputs.

Test Plan:
- Zero-wait memory, RESET_PC=0, mem[0]=0x00000005, mem[1]=0x1C8F2F12, out_ready=1 -> out_valid on the 3rd edge after run; out_pc=0, out_op=0x5, out_const=0x1C8F2F12; next out_pc=2.
- Ack delayed 3 cycles per word -> mem_addr held at 0 then 1 while mem_req=1; out_const=0x3E6F9618 from mem[1]; busy=1 throughout.
- out_ready=0 for 10 cycles after the first instruction -> out_* unchanged; FSM in WAIT_OUT with mem_req=0 after the second fetch; the second instruction appears 1 cycle after out_ready rises.
- jump_valid with jump_addr=0x0041 while FETCH_CONST is waiting for ack -> mem_addr stays 1 until ack; that data is dropped; next request is at 0x0040; out_valid=0 until the new instruction arrives.
- ADDR_WIDTH=4, start at 14 -> fetches 14, 15, then 0; out_pc=14, then 0.
- Reset pulsed while mem_req=1 -> mem_req=0, out_valid=0 and mem_addr=RESET_PC without a clock edge.
